// File: rtl/instruction_loader_if.sv
// Byte-stream and RAM write-port bundle shared by the instruction loader and its environment.
// The master modport is the loader side; the slave modport is the UART/RAM side.
interface instruction_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [23:0]       ram_data;
    logic              ram_ack;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        input  rx_data, rx_valid, ram_ack,
        output ram_we, ram_addr, ram_data, busy, done, error, words_loaded
    );

    modport slave (
        output rx_data, rx_valid, ram_ack,
        input  ram_we, ram_addr, ram_data, busy, done, error, words_loaded
    );
endinterface

// File: rtl/instruction_loader.sv
// Packs framed UART bytes (SYNC, COUNT, 3*N data bytes) into 24-bit words and writes them
// to consecutive instruction-RAM addresses through a we/ack handshake, holding busy meanwhile.
module instruction_loader #(
    parameter int         ADDR_W      = 8,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         BASE_ADDR   = 0,
    parameter int         ACK_TIMEOUT = 4
) (
    input logic                  clk,
    input logic                  rst,
    instruction_loader_if.master bus
);
    localparam int                TW   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_COLLECT, S_WRITE, S_WAIT_ACK, S_DONE, S_ERROR
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W:0]   count, words_loaded;
    logic [ADDR_W-1:0] ram_addr;
    logic [23:0]       ram_data, word_n;
    logic [15:0]       word_buf;
    logic [1:0]        byte_idx, idx_n;
    logic [7:0]        skid_data;
    logic              skid_full;
    logic [TW-1:0]     timer;
    logic              start, sync_seen, last_word, acked, absorb;
    logic              take_skid, take_rx, store_skid, overrun, word_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        sync_seen = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
        start     = sync_seen && (state inside {S_IDLE, S_DONE, S_ERROR});
        last_word = (words_loaded + 1'b1) == count;
        acked     = (state == S_WAIT_ACK) && bus.ram_ack;
        // The ack cycle also absorbs bytes so a continuous byte stream keeps pace with the writes.
        absorb    = (state == S_COLLECT) || (acked && !last_word);
        take_skid = absorb && skid_full;
        take_rx   = absorb && bus.rx_valid && !(take_skid && byte_idx == 2'd2);
        word_n    = {8'h00, word_buf};
        idx_n     = byte_idx;
        if (take_skid) begin
            word_n = {word_n[15:0], skid_data};
            idx_n  = idx_n + 2'd1;
        end
        if (take_rx) begin
            word_n = {word_n[15:0], bus.rx_data};
            idx_n  = idx_n + 2'd1;
        end
        word_done  = absorb && (idx_n == 2'd3);
        store_skid = bus.rx_valid && !take_rx
                     && (state inside {S_COLLECT, S_WRITE, S_WAIT_ACK})
                     && !(acked && last_word);
        overrun    = store_skid && skid_full && !take_skid;

        state_n = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start)                state_n = S_COUNT;
                else if (state == S_DONE) state_n = S_IDLE;
            end
            S_COUNT:    if (bus.rx_valid) state_n = S_COLLECT;
            S_COLLECT:  if (word_done)    state_n = S_WRITE;
            S_WRITE:    state_n = overrun ? S_ERROR : S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (overrun)                              state_n = S_ERROR;
                else if (acked)                           state_n = last_word ? S_DONE : S_COLLECT;
                else if (timer == TW'(ACK_TIMEOUT - 1))   state_n = S_ERROR;
            end
            default:    state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            words_loaded <= '0;
            ram_addr     <= BASE;
            ram_data     <= '0;
            word_buf     <= '0;
            byte_idx     <= '0;
            skid_data    <= '0;
            skid_full    <= 1'b0;
            timer        <= '0;
        end else begin
            if (start) begin
                words_loaded <= '0;
                ram_addr     <= BASE;
                byte_idx     <= '0;
            end
            if (state == S_COUNT && bus.rx_valid) begin
                count    <= (bus.rx_data == 8'd0) ? {1'b1, {ADDR_W{1'b0}}}
                                                  : (ADDR_W + 1)'(bus.rx_data);
                byte_idx <= '0;
            end
            if (absorb) begin
                word_buf <= word_n[15:0];
                byte_idx <= word_done ? 2'd0 : idx_n;
                if (word_done) ram_data <= word_n;
            end
            if (acked) begin
                words_loaded <= words_loaded + 1'b1;
                ram_addr     <= ram_addr + 1'b1;
            end
            if (!(state_n inside {S_COLLECT, S_WRITE, S_WAIT_ACK})) begin
                skid_full <= 1'b0;
            end else if (store_skid) begin
                skid_full <= 1'b1;
                skid_data <= bus.rx_data;
            end else if (take_skid) begin
                skid_full <= 1'b0;
            end
            timer <= (state == S_WAIT_ACK) ? timer + 1'b1 : '0;
        end
    end

    assign bus.ram_we       = (state == S_WRITE);
    assign bus.ram_addr     = ram_addr;
    assign bus.ram_data     = ram_data;
    assign bus.busy         = state inside {S_COUNT, S_COLLECT, S_WRITE, S_WAIT_ACK};
    assign bus.done         = (state == S_DONE);
    assign bus.error        = (state == S_ERROR);
    assign bus.words_loaded = words_loaded;
endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: a scoreboard of expected RAM writes is filled as
// words are sent and drained by a write monitor; a registered-ack RAM model can withhold ack.
module tb_instruction_loader;
    localparam int ADDR_W = 8;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        ack_en = 1'b1;
    int          asserts = 0;
    int          fails   = 0;
    int          we_cnt  = 0;
    int          pushed  = 0;
    logic [7:0]  exp_addr;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;
    int          n;
    int          we0;

    instruction_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instruction_loader #(
        .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .BASE_ADDR(0), .ACK_TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // RAM write port: ack is we registered, unless the bench is withholding it.
    always @(posedge clk or posedge rst) begin
        if (rst) bus.ram_ack <= 1'b0;
        else     bus.ram_ack <= bus.ram_we && ack_en;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.ram_we) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_we", we_cnt, pushed);
            end else begin
                mon_e = exp_q.pop_front();
                check("we_addr", {24'h0, bus.ram_addr}, {24'h0, mon_e[31:24]});
                check("we_data", {8'h0, bus.ram_data}, {8'h0, mon_e[23:0]});
            end
        end
    end

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
    endtask

    task automatic step();
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic start_frame(input logic [7:0] cnt);
        exp_addr = 8'h00;
        put(8'hA5);
        put(cnt);
    endtask

    task automatic send_word(input logic [23:0] w);
        put(w[23:16]);
        put(w[15:8]);
        put(w[7:0]);
        exp_q.push_back({exp_addr, w});
        exp_addr = exp_addr + 8'd1;
        pushed++;
    endtask

    task automatic wait_we(input string tag, input int budget);
        logic got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            if (bus.ram_we) got = 1'b1;
        end
        check(tag, {31'h0, got}, 32'h1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            if (bus.done) got = 1'b1;
        end
        check(tag, {31'h0, got}, 32'h1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_we"},    {31'h0, bus.ram_we},       32'h0);
        check({tag, "_addr"},  {24'h0, bus.ram_addr},     32'h0);
        check({tag, "_data"},  {8'h0, bus.ram_data},      32'h0);
        check({tag, "_busy"},  {31'h0, bus.busy},         32'h0);
        check({tag, "_done"},  {31'h0, bus.done},         32'h0);
        check({tag, "_error"}, {31'h0, bus.error},        32'h0);
        check({tag, "_words"}, {23'h0, bus.words_loaded}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        exp_addr     = 8'h00;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        step();

        // 1: single word frame
        start_frame(8'd1);
        check("t1_busy", {31'h0, bus.busy}, 32'h1);
        send_word(24'hF000AA);
        wait_done("t1_done", 20);
        check("t1_words", {23'h0, bus.words_loaded}, 32'd1);
        check("t1_busy_low", {31'h0, bus.busy}, 32'h0);
        check("t1_we_cnt", we_cnt, 32'd1);
        check("t1_addr_after", {24'h0, bus.ram_addr}, 32'd1);

        // 2: three words, bytes every cycle
        repeat (3) step();
        start_frame(8'd3);
        for (int i = 0; i < 3; i++) send_word(24'($urandom));
        wait_done("t2_done", 30);
        check("t2_words", {23'h0, bus.words_loaded}, 32'd3);
        check("t2_error", {31'h0, bus.error}, 32'h0);
        check("t2_queue", exp_q.size(), 32'd0);

        // 3: count byte 0 means 256 words, address wraps back to 0
        repeat (3) step();
        start_frame(8'd0);
        for (int i = 0; i < 256; i++) send_word(24'($urandom));
        wait_done("t3_done", 50);
        check("t3_words", {23'h0, bus.words_loaded}, 32'd256);
        check("t3_addr_wrap", {24'h0, bus.ram_addr}, 32'd0);
        check("t3_error", {31'h0, bus.error}, 32'h0);
        check("t3_we_cnt", we_cnt, pushed);

        // 4: ack withheld -> timeout after 4 WAIT_ACK cycles, then sync clears error
        repeat (3) step();
        ack_en = 1'b0;
        start_frame(8'd1);
        send_word(24'h123456);
        wait_we("t4_we", 10);
        n = 0;
        while (!bus.error && n < 20) begin
            step();
            n++;
        end
        check("t4_timeout_cycles", n, 32'd5);
        check("t4_busy", {31'h0, bus.busy}, 32'h0);
        repeat (3) step();
        check("t4_error_sticky", {31'h0, bus.error}, 32'h1);
        ack_en = 1'b1;
        start_frame(8'd1);
        check("t4_error_cleared", {31'h0, bus.error}, 32'h0);
        check("t4_busy_again", {31'h0, bus.busy}, 32'h1);
        send_word(24'hABCDEF);
        wait_done("t4_done", 20);
        check("t4_words", {23'h0, bus.words_loaded}, 32'd1);

        // 5: three bytes during a stalled WAIT_ACK -> overrun
        repeat (3) step();
        ack_en = 1'b0;
        start_frame(8'd2);
        send_word(24'h0F1E2D);
        wait_we("t5_we", 10);
        put(8'h11);
        put(8'h22);
        put(8'h33);
        check("t5_overrun_error", {31'h0, bus.error}, 32'h1);
        we0 = we_cnt;
        repeat (10) step();
        check("t5_no_more_we", we_cnt, we0);
        check("t5_busy", {31'h0, bus.busy}, 32'h0);
        ack_en = 1'b1;

        // 6: reset after 4 of 6 data bytes, then a fresh frame from BASE_ADDR
        start_frame(8'd2);
        send_word(24'h445566);
        put(8'h77);
        @(negedge clk);
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        #1;
        check_reset("t6_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("t6_queue", exp_q.size(), 32'd0);
        step();
        start_frame(8'd1);
        send_word(24'h998877);
        wait_done("t6_done", 20);
        check("t6_words", {23'h0, bus.words_loaded}, 32'd1);
        check("t6_addr_after", {24'h0, bus.ram_addr}, 32'd1);

        repeat (3) step();
        check("final_queue", exp_q.size(), 32'd0);
        check("final_we_cnt", we_cnt, pushed);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
